tdm_demux4: RTL

- Receive-side counterpart of the 4:1 channel mux.
- Accepts a time-division-multiplexed stream (one WIDTH-bit word per slot, four slots per frame, frame sync on slot 0) and captures each slot into shadow registers.
- Publishes all four channels together as registered, frame-aligned outputs.
- Detects frame-sync misalignment and counts sync errors.

---
 rtl/tdm_pkg.sv | 24 ++
 rtl/sat_counter.sv | 33 +++
 rtl/tdm_demux4.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: frame-format definitions shared by the TDM transmit mux and the
// receive demux, so both ends agree on slot count and counter width.
//
// Optional feature macro: TDM_DEMUX_PARITY_EN
//   Undefined: 4-slot frame (slots 0..3 carry channels 0..3).
//   Defined  : 5-slot frame; slot 4 carries the even-parity word.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int NUM_SLOTS = 5;
    localparam int SLOT_W    = 3;
`else
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
`endif

    localparam int NUM_CH = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter. It increments on each clock where
// inc_i=1 and holds at all-ones once it gets there. It never wraps.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset (count -> 0)
//   inc_i  increment request
//   cnt_o  current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of the 4-channel TDM link. It captures each slot
// word of a frame into shadow registers. When the frame is complete, it
// publishes all four channels together as registered outputs. It also
// tracks frame-sync alignment and counts sync violations.
//
// Optional feature macro: TDM_DEMUX_PARITY_EN
//   Adds a 5th parity slot (the XOR of slots 0..3) and a parity_err output.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           slot strobe; fs/din are sampled only when en=1
//   fs           frame sync, high with the slot-0 word
//   din          slot data word
//   ch0..ch3     channel words of the last complete frame
//   frame_valid  one-cycle pulse when ch0..ch3 update
//   locked       high while the receiver is in LOCK
//   sync_err     one-cycle pulse on a sync violation
//   parity_err   one-cycle pulse on a parity mismatch (parity build only)
//   err_cnt      saturating sync-violation count
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fs,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     ch0,
    output logic [WIDTH-1:0]     ch1,
    output logic [WIDTH-1:0]     ch2,
    output logic [WIDTH-1:0]     ch3,
    output logic                 frame_valid,
    output logic                 locked,
    output logic                 sync_err,
`ifdef TDM_DEMUX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    state_e                              state_q, state_d;
    logic [SLOT_W-1:0]                   slot_q, slot_d;
    logic [NUM_CH-1:0][WIDTH-1:0]        shadow_q, shadow_d;
    logic [NUM_CH-1:0][WIDTH-1:0]        ch_q, ch_d;
    logic                                fv_q, fv_d;
    logic                                serr_q, serr_d;
    logic                                perr_q, perr_d;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        ch_d     = ch_q;
        fv_d     = 1'b0;
        serr_d   = 1'b0;
        perr_d   = 1'b0;

        if (en) begin
            unique case (state_q)
                HUNT: begin
                    // Words before the first sync are dropped without an error.
                    if (fs) begin
                        shadow_d[0] = din;
                        slot_d      = SLOT_W'(1);
                        state_d     = LOCK;
                    end
                end
                LOCK: begin
                    if (fs) begin
                        // A sync at slot 0 is expected. A sync at any later
                        // slot drops the partial frame and starts a new one
                        // from this word.
                        serr_d      = (slot_q != '0);
                        shadow_d[0] = din;
                        slot_d      = SLOT_W'(1);
                    end else if (slot_q == '0) begin
                        // Sync is missing at the frame start, so the
                        // receiver has lost alignment.
                        serr_d  = 1'b1;
                        state_d = HUNT;
                        slot_d  = '0;
                    end else if (slot_q == LAST_SLOT) begin
                        slot_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        if (din == (shadow_q[0] ^ shadow_q[1] ^ shadow_q[2] ^ shadow_q[3])) begin
                            ch_d = shadow_q;
                            fv_d = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
`else
                        // The slot-3 word goes straight to ch3, so no shadow
                        // register is needed for it.
                        ch_d = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                        fv_d = 1'b1;
`endif
                    end else begin
                        shadow_d[slot_q[1:0]] = din;
                        slot_d                = slot_q + SLOT_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            slot_q   <= '0;
            shadow_q <= '0;
            ch_q     <= '0;
            fv_q     <= 1'b0;
            serr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            ch_q     <= ch_d;
            fv_q     <= fv_d;
            serr_q   <= serr_d;
            perr_q   <= perr_d;
        end
    end

    // The counter is fed from the next-state pulse, so err_cnt changes on
    // the same edge that raises sync_err.
    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (serr_d),
        .cnt_o (err_cnt)
    );

    assign ch0         = ch_q[0];
    assign ch1         = ch_q[1];
    assign ch2         = ch_q[2];
    assign ch3         = ch_q[3];
    assign frame_valid = fv_q;
    assign locked      = (state_q == LOCK);
    assign sync_err    = serr_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err  = perr_q;
`endif

endmodule
